// File: rtl/isa_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
//   ADDR_W / INSTR_W : address and instruction widths (16-bit halfword ISA)
//   INSTR_BYTES      : PC increment per sequential instruction
//   fetch_state_e    : RUN (normal) / FLUSH (stale responses still in flight)
//   fetch_entry_t    : one buffered instruction word with the address it came from
package isa_fetch_pkg;

  localparam int ADDR_W      = 16;
  localparam int INSTR_W     = 16;
  localparam int INSTR_BYTES = 2;

  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 16'h0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

  // Fetch addresses are always halfword aligned; bit 0 of any target is dropped.
  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b0};
  endfunction

  // Sequential successor; the 16-bit add wraps 16'hFFFE to 16'h0000 naturally.
  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] a);
    return a + ADDR_W'(INSTR_BYTES);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO used both as the instruction buffer (fetch_entry_t wide)
// and as the per-request address tag queue (ADDR_W wide).
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data (ignored when full and not popping)
//   pop        : remove head (ignored when empty)
//   flush      : empty the FIFO; takes priority over push and pop
//   head       : current head entry (contents undefined while empty)
//   count      : number of valid entries
//   empty/full : occupancy flags
module if_fifo
  import isa_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = $bits(fetch_entry_t),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately not reset; the count/pointers define validity,
  // and leaving the array reset-free lets it map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch front end: generates the sequential PC+2 request stream
// toward instruction memory, tags each granted request with its address,
// buffers returned words and presents them to decode over valid/ready.
// A redirect (taken branch/jump) restarts the stream and marks every
// in-flight response as stale so it is dropped on return.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   redirect, redirect_pc       : new fetch target (bit 0 ignored)
//   halt                        : suppress new requests, keep draining responses
//   imem_req/addr/gnt           : request channel to instruction memory
//   imem_rvalid/rdata           : in-order response channel
//   if_valid/instr/pc/ready     : decode handshake
// Build option IF_PERF_EN adds saturating counters perf_stall_cycles,
// perf_discards and perf_fetched as extra outputs.
module instr_fetch
  import isa_fetch_pkg::*;
#(
  parameter int                FIFO_DEPTH      = 4,
  parameter int                MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_gnt,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc,
  input  logic               if_ready
`ifdef IF_PERF_EN
  ,
  output logic [15:0]        perf_stall_cycles,
  output logic [15:0]        perf_discards,
  output logic [15:0]        perf_fetched
`endif
);

  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int CRED_W = $clog2(FIFO_DEPTH + MAX_OUTSTANDING + 1) + 1;

  logic               run_en;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [OUT_W-1:0]   outstanding, outstanding_next;
  logic [OUT_W-1:0]   discard, discard_next;
  fetch_state_e       state, state_next;
  logic [CRED_W-1:0]  credit_used;
  logic               grant, drop, data_push;

  logic [ADDR_W-1:0]  tag_pc;
  logic [OUT_W-1:0]   tag_count;
  logic               tag_empty, tag_full;

  fetch_entry_t       push_entry, head_entry;
  logic [FCNT_W-1:0]  fifo_count;
  logic               fifo_empty, fifo_full;

  // Credit check: buffered words plus non-stale requests in flight must fit,
  // so every response that will be kept already owns a FIFO slot.
  assign credit_used = CRED_W'(fifo_count) + CRED_W'(outstanding) - CRED_W'(discard);

  // run_en holds requests off for the first cycle after reset release.
  assign imem_req  = run_en & ~halt & ~redirect
                   & (outstanding < OUT_W'(MAX_OUTSTANDING))
                   & (credit_used < CRED_W'(FIFO_DEPTH));
  assign imem_addr = fetch_addr;
  assign grant     = imem_req & imem_gnt;

  // A response arriving with a redirect belongs to the old stream as well.
  assign drop      = imem_rvalid & (redirect | (state == FLUSH));
  assign data_push = imem_rvalid & ~drop;

  // NOTE: every combinationally assigned variable gets a default before any
  // conditional update, so no latch can be inferred.
  always_comb begin
    outstanding_next = outstanding + OUT_W'(grant) - OUT_W'(imem_rvalid);
    discard_next     = discard;
    if (redirect) begin
      discard_next = outstanding_next;
    end else if (imem_rvalid && state == FLUSH) begin
      discard_next = discard - OUT_W'(1);
    end
    state_next = (discard_next != '0) ? FLUSH : RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_en      <= 1'b0;
      fetch_addr  <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      state       <= RUN;
    end else begin
      run_en      <= 1'b1;
      outstanding <= outstanding_next;
      discard     <= discard_next;
      state       <= state_next;
      if (redirect)   fetch_addr <= align_pc(redirect_pc);
      else if (grant) fetch_addr <= next_pc(fetch_addr);
    end
  end

  // Address of each granted request, popped as its response returns. Never
  // flushed: stale requests still return and must consume their tag.
  if_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (ADDR_W)
  ) u_tag_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant),
    .push_data (fetch_addr),
    .pop       (imem_rvalid),
    .flush     (1'b0),
    .head      (tag_pc),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  assign push_entry = '{instr: imem_rdata, pc: tag_pc};

  if_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_instr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (data_push),
    .push_data (push_entry),
    .pop       (if_ready),
    .flush     (redirect),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // Head fields are zeroed while empty so decode never sees uninitialised storage.
  assign if_valid = ~fifo_empty;
  assign if_instr = if_valid ? head_entry.instr : '0;
  assign if_pc    = if_valid ? head_entry.pc    : '0;

`ifdef IF_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cycles <= '0;
      perf_discards     <= '0;
      perf_fetched      <= '0;
    end else begin
      if (!imem_req && !halt && !redirect) perf_stall_cycles <= sat_inc16(perf_stall_cycles);
      if (drop)                            perf_discards     <= sat_inc16(perf_discards);
      if (data_push)                       perf_fetched      <= sat_inc16(perf_fetched);
    end
  end
`endif

  a_no_stale_rsp: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (outstanding != '0) && !tag_empty);
  a_tag_tracks: assert property (@(posedge clk) disable iff (!rst_n)
    tag_count == outstanding);
  a_tag_room: assert property (@(posedge clk) disable iff (!rst_n)
    grant |-> !tag_full);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    data_push |-> (!fifo_full || if_ready));
  a_state_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    (state == FLUSH) == (discard != '0));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. A small memory responder inside step()
// returns rdata = addr ^ 16'hA5A5 one cycle after each grant (when enabled),
// and every word handed to decode is logged for in-order comparison.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect, halt, imem_gnt, imem_rvalid, if_ready;
  logic [15:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [15:0] imem_addr, if_instr, if_pc;
`ifdef IF_PERF_EN
  logic [15:0] perf_stall_cycles, perf_discards, perf_fetched;
`endif

  int checks = 0;
  int errors = 0;
  bit rsp_en;
  logic [15:0] pend[$];
  logic [15:0] got_pc[$];
  logic [15:0] got_ins[$];

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready)
`ifdef IF_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_discards     (perf_discards),
    .perf_fetched      (perf_fetched)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] got_pc_at(input int i);
    return (i < got_pc.size()) ? got_pc[i] : 16'hxxxx;
  endfunction

  function automatic logic [15:0] got_ins_at(input int i);
    return (i < got_ins.size()) ? got_ins[i] : 16'hxxxx;
  endfunction

  task automatic chk_got(input string tag, input int i, input logic [15:0] pc);
    chk({tag, "_pc"}, got_pc_at(i), pc);
    chk({tag, "_instr"}, got_ins_at(i), pc ^ 16'hA5A5);
  endtask

  // One clock: sample handshakes before the edge, then update the responder.
  task automatic step();
    logic g, r;
    logic [15:0] a;
    #1;
    g = imem_req & imem_gnt;
    a = imem_addr;
    r = imem_rvalid;
    if (if_valid && if_ready) begin
      got_pc.push_back(if_pc);
      got_ins.push_back(if_instr);
    end
    @(posedge clk);
    #1;
    if (r && pend.size() > 0) void'(pend.pop_front());
    if (g) pend.push_back(a);
    if (rsp_en && pend.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0] ^ 16'hA5A5;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 16'h0000;
    end
    #1;
  endtask

  task automatic do_reset(input bit rsp, input bit ready);
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    halt        = 1'b0;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0000;
    if_ready    = ready;
    rsp_en      = rsp;
    pend.delete();
    got_pc.delete();
    got_ins.delete();
    @(posedge clk);
    #3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    // ---- Reset state and streaming with 1-cycle memory latency ----
    do_reset(1'b1, 1'b1);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 16'h0000);
    chk("rst_valid", if_valid, 1'b0);
    chk("rst_instr", if_instr, 16'h0000);
    chk("rst_pc", if_pc, 16'h0000);
`ifdef IF_PERF_EN
    chk("rst_perf_discards", perf_discards, 16'h0000);
`endif
    rst_n = 1'b1;
    step();
    chk("first_req", imem_req, 1'b1);
    chk("first_addr", imem_addr, 16'h0000);
    step();
    chk("valid_cyc2", if_valid, 1'b0);
    step();
    chk("valid_cyc3", if_valid, 1'b1);
    chk("head_pc_cyc3", if_pc, 16'h0000);
    chk("head_instr_cyc3", if_instr, 16'hA5A5);
    repeat (3) step();
    chk_got("seq0", 0, 16'h0000);
    chk_got("seq1", 1, 16'h0002);
    chk_got("seq2", 2, 16'h0004);

    // ---- Decode stalled: buffer fills to exactly FIFO_DEPTH ----
    if_ready = 1'b0;
    repeat (6) step();
    chk("full_req", imem_req, 1'b0);
    chk("full_head_valid", if_valid, 1'b1);
    chk("full_head_pc", if_pc, 16'h0006);
    chk("full_next_addr", imem_addr, 16'h000E);
    chk("full_no_pops", got_pc.size(), 3);
    if_ready = 1'b1;
    got_pc.delete();
    got_ins.delete();
    repeat (5) step();
    chk_got("resume0", 0, 16'h0006);
    chk_got("resume1", 1, 16'h0008);
    chk_got("resume2", 2, 16'h000A);
    chk_got("resume3", 3, 16'h000C);
    chk_got("resume4", 4, 16'h000E);

    // ---- Redirect with two requests in flight ----
    do_reset(1'b0, 1'b1);
    rst_n = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    #1;
    chk("redir_latency_req", imem_req, 1'b1);
    chk("redir_latency_addr", imem_addr, 16'h0010);
    step();
    step();
    chk("max_outstanding_req", imem_req, 1'b0);
    redirect = 1'b1;
    redirect_pc = 16'h0101;
    rsp_en = 1'b1;
    #1;
    chk("redir_forces_req0", imem_req, 1'b0);
    step();
    redirect = 1'b0;
    #1;
    chk("redir_flush_valid", if_valid, 1'b0);
    step();
    chk("target_req", imem_req, 1'b1);
    chk("target_addr", imem_addr, 16'h0100);
    step();
    step();
    chk("target_valid", if_valid, 1'b1);
    chk("target_pc", if_pc, 16'h0100);
    chk("target_instr", if_instr, 16'h0100 ^ 16'hA5A5);
    chk("stale_never_popped", got_pc.size(), 0);
`ifdef IF_PERF_EN
    chk("perf_discards_2", perf_discards, 16'd2);
`endif

    // ---- Redirect coinciding with an arriving response ----
    redirect = 1'b1;
    redirect_pc = 16'h0200;
    #1;
    chk("redir_rvalid_req0", imem_req, 1'b0);
    step();
    redirect = 1'b0;
    #1;
    chk("redir_rvalid_flush", if_valid, 1'b0);
    chk("redir_rvalid_next_req", imem_req, 1'b1);
    chk("redir_rvalid_next_addr", imem_addr, 16'h0200);
`ifdef IF_PERF_EN
    chk("perf_discards_3", perf_discards, 16'd3);
`endif
    got_pc.delete();
    got_ins.delete();
    repeat (4) step();
    chk_got("redir2_0", 0, 16'h0200);
    chk_got("redir2_1", 1, 16'h0202);

    // ---- Halt with two requests in flight ----
    do_reset(1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) step();
    chk("halt_setup_req", imem_req, 1'b0);
    halt = 1'b1;
    rsp_en = 1'b1;
    step();
    chk("halt_req_a", imem_req, 1'b0);
    step();
    chk("halt_req_b", imem_req, 1'b0);
    step();
    chk("halt_req_c", imem_req, 1'b0);
    chk("halt_drain_valid", if_valid, 1'b1);
    chk("halt_drain_pc", if_pc, 16'h0000);
    chk("halt_drain_instr", if_instr, 16'hA5A5);
    halt = 1'b0;
    #1;
    chk("unhalt_req", imem_req, 1'b1);
    chk("unhalt_addr", imem_addr, 16'h0004);
    if_ready = 1'b1;
    repeat (2) step();
    chk_got("halt_word0", 0, 16'h0000);
    chk_got("halt_word1", 1, 16'h0002);

    // ---- Address wrap 16'hFFFE -> 16'h0000 (odd target, bit 0 forced low) ----
    redirect = 1'b1;
    redirect_pc = 16'hFFFF;
    step();
    redirect = 1'b0;
    #1;
    chk("wrap_start_req", imem_req, 1'b1);
    chk("wrap_start_addr", imem_addr, 16'hFFFE);
    got_pc.delete();
    got_ins.delete();
    step();
    chk("wrap_next_addr", imem_addr, 16'h0000);
    repeat (3) step();
    chk_got("wrap0", 0, 16'hFFFE);
    chk_got("wrap1", 1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
